crc_mem_checker: RTL

- Parametrised successor to the fixed CRC-16 memory checker in crc_system.
- On crc_start, streams a runtime-selected number of words from a synchronous-read memory, starting at a runtime address.
- Computes a CRC with configurable width, polynomial, init, reflection and final XOR.
- Compares the result against crc_out_target; adds abort, busy and zero-length handling.

---
 rtl/crc_pkg.sv | 45 ++++
 rtl/crc_word_update.sv | 32 +++
 rtl/crc_mem_checker.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared types, presets and helpers for the CRC memory checker family.
package crc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCalc,
        StDone
    } crc_state_t;

    // Algorithm presets; fields are 32 bits wide, narrower CRCs use the low bits.
    typedef struct packed {
        logic [31:0] poly;
        logic [31:0] init;
        logic [31:0] xor_out;
        logic        refl_in;
        logic        refl_out;
    } crc_preset_t;

    localparam crc_preset_t CRC16_ARC = '{
        poly: 32'h0000_8005, init: 32'h0000_0000, xor_out: 32'h0000_0000,
        refl_in: 1'b1, refl_out: 1'b1
    };

    localparam crc_preset_t CRC16_CCITT_FALSE = '{
        poly: 32'h0000_1021, init: 32'h0000_FFFF, xor_out: 32'h0000_0000,
        refl_in: 1'b0, refl_out: 1'b0
    };

    localparam crc_preset_t CRC32 = '{
        poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF, xor_out: 32'hFFFF_FFFF,
        refl_in: 1'b1, refl_out: 1'b1
    };

    // Reverse the low 'width' bits of value (width 1..32); result is right-aligned.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                                input int unsigned width);
        logic [31:0] rev;
        for (int i = 0; i < 32; i++) begin
            rev[i] = value[31-i];
        end
        return rev >> (32 - width);
    endfunction

endpackage

// File: rtl/crc_word_update.sv
// Combinational CRC update over one data word (serial MSB-first LFSR, unrolled).
module crc_word_update
    import crc_pkg::*;
#(
    parameter int unsigned       CRC_W   = 16,
    parameter logic [CRC_W-1:0]  POLY    = 16'h8005,
    parameter int unsigned       DATA_W  = 8,
    parameter bit                REFL_IN = 1'b1
) (
    input  logic [CRC_W-1:0]  crc_cur,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_next
);

    logic [DATA_W-1:0] data_ord;
    logic [CRC_W-1:0]  lfsr;

    // Optionally reflect the word, then shift it through the LFSR one bit at a time
    always_comb begin
        data_ord = REFL_IN ? DATA_W'(bit_reverse(32'(data), DATA_W)) : data;
        lfsr     = crc_cur;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (lfsr[CRC_W-1] ^ data_ord[i]) begin
                lfsr = (lfsr << 1) ^ POLY;
            end else begin
                lfsr = lfsr << 1;
            end
        end
        crc_next = lfsr;
    end

endmodule

// File: rtl/crc_mem_checker.sv
// Streams words from a synchronous-read memory, computes a CRC and compares it to a target.
module crc_mem_checker
    import crc_pkg::*;
#(
    parameter int unsigned       CRC_W    = 16,
    parameter logic [CRC_W-1:0]  POLY     = 16'h8005,
    parameter logic [CRC_W-1:0]  INIT     = 16'h0000,
    parameter logic [CRC_W-1:0]  XOR_OUT  = 16'h0000,
    parameter bit                REFL_IN  = 1'b1,
    parameter bit                REFL_OUT = 1'b1,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       LEN_W    = 11
) (
    input  logic              clk50m,
    input  logic              rst_n,
    input  logic              crc_start,
    input  logic              crc_abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  byte_count,
    input  logic [CRC_W-1:0]  crc_out_target,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              busy,
    output logic              crc_rdy,
    output logic              crc_ok,
    output logic [CRC_W-1:0]  crc_out
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

    function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] value);
        logic [CRC_W-1:0] v;
        v = REFL_OUT ? CRC_W'(bit_reverse(32'(value), CRC_W)) : value;
        return v ^ XOR_OUT;
    endfunction

    crc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              busy_q, busy_d;
    logic              crc_rdy_q, crc_rdy_d;
    logic              crc_ok_q, crc_ok_d;
    logic [CRC_W-1:0]  crc_out_q, crc_out_d;
    logic [CRC_W-1:0]  crc_reg_q, crc_reg_d;
    logic [CRC_W-1:0]  target_q, target_d;
    logic [LEN_W-1:0]  issue_left_q, issue_left_d;  // addresses still to issue after current
    logic [LEN_W-1:0]  rem_q, rem_d;                // words still to consume
    logic              rd_dly_q, rd_dly_d;          // a read is in flight in the memory
    logic [DATA_W-1:0] data_q, data_d;              // registered memory data
    logic              data_vld_q, data_vld_d;

    logic [LEN_W-1:0]  len_sat;
    logic [CRC_W-1:0]  crc_step;
    logic [CRC_W-1:0]  crc_fin;
    logic [CRC_W-1:0]  init_fin;

    assign len_sat  = (byte_count > MAX_LEN) ? MAX_LEN : byte_count;
    assign crc_fin  = finalize(crc_step);
    assign init_fin = finalize(INIT);

    crc_word_update #(
        .CRC_W   (CRC_W),
        .POLY    (POLY),
        .DATA_W  (DATA_W),
        .REFL_IN (REFL_IN)
    ) u_word_update (
        .crc_cur  (crc_reg_q),
        .data     (data_q),
        .crc_next (crc_step)
    );

    // State register with synchronous active-low reset
    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            crc_rdy_q    <= 1'b0;
            crc_ok_q     <= 1'b0;
            crc_out_q    <= '0;
            crc_reg_q    <= '0;
            target_q     <= '0;
            issue_left_q <= '0;
            rem_q        <= '0;
            rd_dly_q     <= 1'b0;
            data_q       <= '0;
            data_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            busy_q       <= busy_d;
            crc_rdy_q    <= crc_rdy_d;
            crc_ok_q     <= crc_ok_d;
            crc_out_q    <= crc_out_d;
            crc_reg_q    <= crc_reg_d;
            target_q     <= target_d;
            issue_left_q <= issue_left_d;
            rem_q        <= rem_d;
            rd_dly_q     <= rd_dly_d;
            data_q       <= data_d;
            data_vld_q   <= data_vld_d;
        end
    end

    // Next-state: address issue, data pipeline, CRC accumulation and result reporting
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = mem_rd_q;
        busy_d       = busy_q;
        crc_rdy_d    = crc_rdy_q;
        crc_ok_d     = crc_ok_q;
        crc_out_d    = crc_out_q;
        crc_reg_d    = crc_reg_q;
        target_d     = target_q;
        issue_left_d = issue_left_q;
        rem_d        = rem_q;
        // Read data appears one cycle after the address and is registered here
        rd_dly_d     = mem_rd_q;
        data_d       = mem_data;
        data_vld_d   = rd_dly_q;

        if (crc_abort) begin
            // Abort outranks start; idle/done states simply drop any start
            if (state_q inside {StFetch, StCalc}) begin
                state_d    = StIdle;
                busy_d     = 1'b0;
                mem_rd_d   = 1'b0;
                crc_rdy_d  = 1'b0;
                rd_dly_d   = 1'b0;
                data_vld_d = 1'b0;
            end
        end else begin
            // Keep issuing addresses until the last one has been presented
            if ((state_q inside {StFetch, StCalc}) && mem_rd_q) begin
                if (issue_left_q == '0) begin
                    mem_rd_d = 1'b0;
                end else begin
                    mem_addr_d   = mem_addr_q + 1'b1;
                    issue_left_d = issue_left_q - 1'b1;
                end
            end

            case (state_q)
                StIdle, StDone: begin
                    if (crc_start) begin
                        if (len_sat == '0) begin
                            crc_out_d = init_fin;
                            crc_ok_d  = (init_fin == crc_out_target);
                            crc_rdy_d = 1'b1;
                            state_d   = StDone;
                        end else begin
                            target_d     = crc_out_target;
                            crc_reg_d    = INIT;
                            mem_addr_d   = start_addr;
                            mem_rd_d     = 1'b1;
                            busy_d       = 1'b1;
                            crc_rdy_d    = 1'b0;
                            issue_left_d = len_sat - 1'b1;
                            rem_d        = len_sat;
                            rd_dly_d     = 1'b0;
                            data_vld_d   = 1'b0;
                            state_d      = StFetch;
                        end
                    end
                end
                StFetch: begin
                    state_d = StCalc;
                end
                StCalc: begin
                    if (data_vld_q) begin
                        crc_reg_d = crc_step;
                        rem_d     = rem_q - 1'b1;
                        if (rem_q == LEN_W'(1)) begin
                            crc_out_d = crc_fin;
                            crc_ok_d  = (crc_fin == target_q);
                            crc_rdy_d = 1'b1;
                            busy_d    = 1'b0;
                            mem_rd_d  = 1'b0;
                            state_d   = StDone;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign busy     = busy_q;
    assign crc_rdy  = crc_rdy_q;
    assign crc_ok   = crc_ok_q;
    assign crc_out  = crc_out_q;

endmodule
